// File: rtl/cn1_pipe_pkg.sv
// Shared CN1 pipeline types: fetch FSM states and default widths.
// No logic; imported by the fetch stage and its PC incrementer.
// No flow control of its own.
package cn1_pipe_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int PC_STEP_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DROP
    } fetch_state_e;

endpackage

// File: rtl/pc_incr.sv
// Sequential PC incrementer: PC + PC_STEP modulo 2^XLEN.
// Purely combinational, zero latency.
// No flow control.
module pc_incr
    import cn1_pipe_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int PC_STEP = PC_STEP_DEF
) (
    input  logic [XLEN-1:0] i_pc,
    output logic [XLEN-1:0] o_pc_next
);

    assign o_pc_next = i_pc + XLEN'(PC_STEP);

endmodule

// File: rtl/if_fetch.sv
// CN1 instruction fetch: PC, one outstanding imem request, IF/ID register; FETCH_STAT_EN adds counters.
// Latency: response in cycle N is visible on IF/ID in cycle N+1; redirect retargets the next request.
// Backpressure: decode stall parks one response in a holding buffer and stops requesting until drained.
module if_fetch
    import cn1_pipe_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = PC_STEP_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            if_id_ready,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc_next,
`ifdef FETCH_STAT_EN
    output logic [31:0]     if_id_instr,
    output logic [31:0]     stat_fetched,
    output logic [31:0]     stat_stall
`else
    output logic [31:0]     if_id_instr
`endif
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_plus;
    logic            r_if_vld;
    logic [XLEN-1:0] r_if_pc;
    logic [XLEN-1:0] r_if_pc_next;
    logic [31:0]     r_if_instr;
    // Buffer contents are only meaningful while in HOLD; the state is its valid bit.
    logic [XLEN-1:0] r_buf_pc;
    logic [XLEN-1:0] r_buf_pc_next;
    logic [31:0]     r_buf_instr;

    logic w_accept;
    logic w_if_free;
    logic w_ld_rsp;
    logic w_ld_buf;
    logic w_ld_hold;
    logic w_pc_adv;

    pc_incr #(
        .XLEN    (XLEN),
        .PC_STEP (PC_STEP)
    ) u_pc_incr (
        .i_pc      (r_pc),
        .o_pc_next (w_pc_plus)
    );

    assign w_accept  = (r_state == REQ) && imem_req_ready;
    assign w_if_free = !r_if_vld || if_id_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ld_rsp    = 1'b0;
        w_ld_buf    = 1'b0;
        w_ld_hold   = 1'b0;
        w_pc_adv    = 1'b0;
        case (r_state)
            IDLE: w_state_nxt = REQ;
            REQ:  if (w_accept) w_state_nxt = WAIT;
            WAIT: begin
                if (imem_rsp_valid) begin
                    w_pc_adv = 1'b1;
                    if (w_if_free) begin
                        w_ld_rsp    = 1'b1;
                        w_state_nxt = REQ;
                    end else begin
                        w_ld_buf    = 1'b1;
                        w_state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (if_id_ready) begin
                    w_ld_hold   = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            DROP:    if (imem_rsp_valid) w_state_nxt = REQ;
            default: w_state_nxt = IDLE;
        endcase

        // A redirect kills all loads; an in-flight request must still be drained via DROP.
        if (redirect_valid) begin
            w_ld_rsp  = 1'b0;
            w_ld_buf  = 1'b0;
            w_ld_hold = 1'b0;
            w_pc_adv  = 1'b0;
            case (r_state)
                REQ:        w_state_nxt = w_accept ? DROP : REQ;
                WAIT, DROP: w_state_nxt = imem_rsp_valid ? REQ : DROP;
                default:    w_state_nxt = REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_if_vld      <= 1'b0;
            r_if_pc       <= '0;
            r_if_pc_next  <= '0;
            r_if_instr    <= '0;
            r_buf_pc      <= '0;
            r_buf_pc_next <= '0;
            r_buf_instr   <= '0;
        end else begin
            if (redirect_valid) begin
                r_pc <= redirect_pc;
            end else if (w_pc_adv) begin
                r_pc <= w_pc_plus;
            end

            if (w_ld_rsp) begin
                r_if_pc      <= r_pc;
                r_if_pc_next <= w_pc_plus;
                r_if_instr   <= imem_rdata;
            end else if (w_ld_hold) begin
                r_if_pc      <= r_buf_pc;
                r_if_pc_next <= r_buf_pc_next;
                r_if_instr   <= r_buf_instr;
            end

            if (redirect_valid) begin
                r_if_vld <= 1'b0;
            end else if (w_ld_rsp || w_ld_hold) begin
                r_if_vld <= 1'b1;
            end else if (if_id_ready) begin
                r_if_vld <= 1'b0;
            end

            if (w_ld_buf) begin
                r_buf_pc      <= r_pc;
                r_buf_pc_next <= w_pc_plus;
                r_buf_instr   <= imem_rdata;
            end
        end
    end

`ifdef FETCH_STAT_EN
    logic [31:0] r_stat_fetched;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_fetched <= '0;
            r_stat_stall   <= '0;
        end else begin
            if (w_ld_rsp || w_ld_hold) begin
                r_stat_fetched <= r_stat_fetched + 32'd1;
            end
            if ((r_state == HOLD) || ((r_state == REQ) && !imem_req_ready)) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_fetched = r_stat_fetched;
    assign stat_stall   = r_stat_stall;
`endif

    assign imem_req_valid = (r_state == REQ);
    assign imem_addr      = r_pc;
    assign if_id_valid    = r_if_vld;
    assign if_id_pc       = r_if_pc;
    assign if_id_pc_next  = r_if_pc_next;
    assign if_id_instr    = r_if_instr;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: reset, streaming, decode backpressure, redirects, PC wrap.
// A second instance with RESET_PC = 0xFFFF_FFFC covers the wrap case.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_ready;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_next;
    logic [31:0] if_id_instr;

    logic        wr_req_valid;
    logic        wr_req_ready;
    logic [31:0] wr_addr;
    logic        wr_rsp_valid;
    logic [31:0] wr_rdata;
    logic        wr_redirect_valid;
    logic [31:0] wr_redirect_pc;
    logic        wr_if_ready;
    logic        wr_if_valid;
    logic [31:0] wr_if_pc;
    logic [31:0] wr_if_pc_next;
    logic [31:0] wr_if_instr;

`ifdef FETCH_STAT_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_stall;
    logic [31:0] wr_stat_fetched;
    logic [31:0] wr_stat_stall;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;

    bit          m_busy;
    int          m_cnt;
    int          rsp_lat;
    logic [31:0] m_addr;
    bit          w_acc;
    logic [31:0] w_acc_addr;

    always #5 clk = ~clk;

    if_fetch u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_ready    (if_id_ready),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_pc_next  (if_id_pc_next),
`ifdef FETCH_STAT_EN
        .if_id_instr    (if_id_instr),
        .stat_fetched   (stat_fetched),
        .stat_stall     (stat_stall)
`else
        .if_id_instr    (if_id_instr)
`endif
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (wr_req_valid),
        .imem_req_ready (wr_req_ready),
        .imem_addr      (wr_addr),
        .imem_rsp_valid (wr_rsp_valid),
        .imem_rdata     (wr_rdata),
        .redirect_valid (wr_redirect_valid),
        .redirect_pc    (wr_redirect_pc),
        .if_id_ready    (wr_if_ready),
        .if_id_valid    (wr_if_valid),
        .if_id_pc       (wr_if_pc),
        .if_id_pc_next  (wr_if_pc_next),
`ifdef FETCH_STAT_EN
        .if_id_instr    (wr_if_instr),
        .stat_fetched   (wr_stat_fetched),
        .stat_stall     (wr_stat_stall)
`else
        .if_id_instr    (wr_if_instr)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic expect_ifid(input string tag, input logic [31:0] pc,
                               input logic [31:0] pc_next, input logic [31:0] instr);
        check_val({tag, "_vld"},   32'(if_id_valid), 32'd1);
        check_val({tag, "_pc"},    if_id_pc,         pc);
        check_val({tag, "_pcnx"},  if_id_pc_next,    pc_next);
        check_val({tag, "_instr"}, if_id_instr,      instr);
    endtask

    // One clock: capture accepts, cross the edge, drive memory responses for the new cycle.
    task automatic cyc();
        if (imem_req_valid && imem_req_ready && rst_n) begin
            m_busy = 1'b1;
            m_cnt  = rsp_lat;
            m_addr = imem_addr;
        end
        w_acc      = wr_req_valid && wr_req_ready && rst_n;
        w_acc_addr = wr_addr;
        @(posedge clk);
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_busy         = 1'b0;
                imem_rsp_valid = 1'b1;
                imem_rdata     = mem_word(m_addr);
            end
        end
        wr_rsp_valid = w_acc;
        wr_rdata     = mem_word(w_acc_addr);
    endtask

    task automatic do_reset();
        rst_n             = 1'b0;
        imem_req_ready    = 1'b1;
        imem_rsp_valid    = 1'b0;
        imem_rdata        = '0;
        redirect_valid    = 1'b0;
        redirect_pc       = '0;
        if_id_ready       = 1'b1;
        wr_req_ready      = 1'b1;
        wr_rsp_valid      = 1'b0;
        wr_rdata          = '0;
        wr_redirect_valid = 1'b0;
        wr_redirect_pc    = '0;
        wr_if_ready       = 1'b1;
        m_busy            = 1'b0;
        m_cnt             = 0;
        rsp_lat           = 1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset values, then four REQ cycles stalled by the memory.
        do_reset();
        imem_req_ready = 1'b0;
        check_val("rst_req_vld", 32'(imem_req_valid), 32'd0);
        check_val("rst_addr",    imem_addr,           32'h0000_0000);
        check_val("rst_if_vld",  32'(if_id_valid),    32'd0);
        check_val("rst_if_pc",   if_id_pc,            32'h0);
        check_val("rst_if_pcnx", if_id_pc_next,       32'h0);
        check_val("rst_if_ins",  if_id_instr,         32'h0);
        check_val("rst_wr_addr", wr_addr,             32'hFFFF_FFFC);
`ifdef FETCH_STAT_EN
        check_val("rst_stat_f",  stat_fetched,        32'd0);
        check_val("rst_stat_s",  stat_stall,          32'd0);
`endif
        cyc();
        for (int i = 0; i < 4; i++) begin
            check_val("stall_req_vld", 32'(imem_req_valid), 32'd1);
            check_val("stall_addr",    imem_addr,           32'h0);
            check_val("stall_if_vld",  32'(if_id_valid),    32'd0);
            if (i == 2) begin
                check_val("wrap_vld",   32'(wr_if_valid), 32'd1);
                check_val("wrap_pc",    wr_if_pc,         32'hFFFF_FFFC);
                check_val("wrap_pcnx",  wr_if_pc_next,    32'h0000_0000);
                check_val("wrap_instr", wr_if_instr,      32'h2152_FFFC);
                check_val("wrap_addr",  wr_addr,          32'h0000_0000);
`ifdef FETCH_STAT_EN
                check_val("wrap_stat_f", wr_stat_fetched, 32'd1);
                check_val("wrap_stat_s", wr_stat_stall,   32'd0);
`endif
            end
            cyc();
        end

        // Streaming: one instruction every two cycles.
        imem_req_ready = 1'b1;
        cyc();
        check_val("s_wait_if_vld", 32'(if_id_valid), 32'd0);
        cyc();
        expect_ifid("s0", 32'h0, 32'h4, 32'hDEAD_0000);
        check_val("s0_addr", imem_addr, 32'h4);
        cyc();
        check_val("s_consumed", 32'(if_id_valid), 32'd0);
        cyc();
        expect_ifid("s1", 32'h4, 32'h8, 32'hDEAD_0004);
        cyc();
        cyc();
        expect_ifid("s2", 32'h8, 32'hC, 32'hDEAD_0008);
        check_val("s2_addr", imem_addr, 32'hC);
`ifdef FETCH_STAT_EN
        check_val("stat_fetched", stat_fetched, 32'd3);
        check_val("stat_stall",   stat_stall,   32'd4);
`endif

        // Decode backpressure for five cycles after the first load.
        do_reset();
        cyc();
        cyc();
        cyc();
        expect_ifid("bp0", 32'h0, 32'h4, 32'hDEAD_0000);
        if_id_ready = 1'b0;
        cyc();
        check_val("bp_a_pc", if_id_pc, 32'h0);
        cyc();
        check_val("bp_hold_req", 32'(imem_req_valid), 32'd0);
        check_val("bp_hold_pc",  if_id_pc,            32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_val("bp_hold_req", 32'(imem_req_valid), 32'd0);
            check_val("bp_hold_vld", 32'(if_id_valid),    32'd1);
        end
        if_id_ready = 1'b1;
        cyc();
        expect_ifid("bp1", 32'h4, 32'h8, 32'hDEAD_0004);
        check_val("bp1_req",  32'(imem_req_valid), 32'd1);
        check_val("bp1_addr", imem_addr,           32'h8);

        // Redirect while waiting on a slow response.
        rsp_lat = 3;
        cyc();
        check_val("rw_wait_vld", 32'(if_id_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        cyc();
        redirect_valid = 1'b0;
        check_val("rw_drop_req", 32'(imem_req_valid), 32'd0);
        check_val("rw_drop_vld", 32'(if_id_valid),    32'd0);
        cyc();
        check_val("rw_drop2_req", 32'(imem_req_valid), 32'd0);
        cyc();
        check_val("rw_req",     32'(imem_req_valid), 32'd1);
        check_val("rw_addr",    imem_addr,           32'h100);
        check_val("rw_no_leak", 32'(if_id_valid),    32'd0);
        rsp_lat = 1;
        cyc();
        cyc();
        expect_ifid("rw", 32'h100, 32'h104, 32'hDEAD_0100);

        // Redirect coinciding with the response.
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        cyc();
        redirect_valid = 1'b0;
        check_val("sim_req",  32'(imem_req_valid), 32'd1);
        check_val("sim_addr", imem_addr,           32'h200);
        check_val("sim_vld",  32'(if_id_valid),    32'd0);
        cyc();
        cyc();
        expect_ifid("sim", 32'h200, 32'h204, 32'hDEAD_0200);

        // Redirect to an unaligned target while the request is unaccepted.
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0301;
        cyc();
        redirect_valid = 1'b0;
        check_val("ua_req",  32'(imem_req_valid), 32'd1);
        check_val("ua_addr", imem_addr,           32'h301);
        check_val("ua_vld",  32'(if_id_valid),    32'd0);
        imem_req_ready = 1'b1;
        cyc();
        cyc();
        expect_ifid("ua", 32'h301, 32'h305, 32'hDEAD_0301);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
